// File: rtl/if_id_stage_pkg.sv
// Shared constants for the fetch stage: jump-op encoding, bubble instruction, PC increment.
package if_id_stage_pkg;

    localparam logic [1:0]  JOP_NONE  = 2'd0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          PC_STEP   = 4;

    // Any nonzero jump op means EX resolved a taken control transfer.
    function automatic logic jop_taken(input logic [1:0] jop);
        return jop != JOP_NONE;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [width-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + width'(1);
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and debug event counters.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter int                  bit_size = 32,
    parameter logic [bit_size-1:0] pc_reset = 32'h0,
    parameter int                  cnt_size = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                PCWrite,
    input  logic                IF_IDWrite,
    input  logic                IF_Flush,
    input  logic [1:0]          EX_JumpOP,
    input  logic [bit_size-1:0] EX_Target,
    input  logic [bit_size-1:0] IM_Instr,
    output logic [bit_size-1:0] IM_Address,
    output logic [bit_size-1:0] ID_PC,
    output logic [bit_size-1:0] ID_Instr,
    output logic                ID_Valid,
    output logic [cnt_size-1:0] stall_cnt,
    output logic [cnt_size-1:0] flush_cnt,
    output logic [cnt_size-1:0] fetch_cnt
);

    logic [bit_size-1:0] pc;
    logic [bit_size-1:0] pc_plus4;
    logic [bit_size-1:0] target_aligned;
    logic                redirect;
    logic                fetch_load;

    assign pc_plus4       = pc + bit_size'(PC_STEP);
    assign target_aligned = EX_Target & ~bit_size'(3);
    assign redirect       = jop_taken(EX_JumpOP);
    assign fetch_load     = !IF_Flush && IF_IDWrite;
    assign IM_Address     = pc;

    // A resolved redirect beats a load-use stall; PC+4 wraps silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= pc_reset;
        end else if (redirect) begin
            pc <= target_aligned;
        end else if (PCWrite) begin
            pc <= pc_plus4;
        end
    end

    // Flush beats the hold request so a wrong-path fetch can never linger in ID.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ID_PC    <= '0;
            ID_Instr <= bit_size'(NOP_INSTR);
            ID_Valid <= 1'b0;
        end else if (IF_Flush) begin
            ID_PC    <= '0;
            ID_Instr <= bit_size'(NOP_INSTR);
            ID_Valid <= 1'b0;
        end else if (IF_IDWrite) begin
            ID_PC    <= pc_plus4;
            ID_Instr <= IM_Instr;
            ID_Valid <= 1'b1;
        end
    end

    sat_counter #(.width(cnt_size)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!PCWrite && !redirect),
        .count (stall_cnt)
    );

    sat_counter #(.width(cnt_size)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (IF_Flush),
        .count (flush_cnt)
    );

    sat_counter #(.width(cnt_size)) u_fetch_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (fetch_load),
        .count (fetch_cnt)
    );

endmodule
